// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter in front of a single external memory bus sequencer.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-break; default build gives master 0 priority.
module mem_bus_arbiter (
  input  logic        clk,
  input  logic        reset_in,
  // master 0 (CPU)
  input  logic [14:0] m0_raddr,
  input  logic        m0_rreq,
  output logic [15:0] m0_rdata,
  output logic        m0_rdone,
  input  logic [14:0] m0_waddr,
  input  logic [1:0]  m0_wmask,
  input  logic [15:0] m0_wdata,
  output logic        m0_wdone,
  // master 1 (loader/DMA)
  input  logic [14:0] m1_raddr,
  input  logic        m1_rreq,
  output logic [15:0] m1_rdata,
  output logic        m1_rdone,
  input  logic [14:0] m1_waddr,
  input  logic [1:0]  m1_wmask,
  input  logic [15:0] m1_wdata,
  output logic        m1_wdone,
  // external bus sequencer
  output logic [14:0] d_raddr,
  output logic        d_rreq,
  input  logic [15:0] d_rdata,
  input  logic        d_rdone,
  output logic [14:0] d_waddr,
  output logic [1:0]  d_wmask,
  output logic [15:0] d_wdata,
  input  logic        d_wdone,
  output logic        grant,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StWr, StRd} state_e;

  state_e      state_q, state_d;
  logic        owner_q;
  logic        last_q;
  logic [14:0] addr_q;
  logic [1:0]  mask_q;
  logic [15:0] data_q;

  logic pend0, pend1;
  logic tie_winner;
  logic winner;
  logic win_wr;
  logic start;
  logic xfer_done;

  assign pend0 = m0_rreq | (m0_wmask != 2'b00);
  assign pend1 = m1_rreq | (m1_wmask != 2'b00);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign tie_winner = ~last_q;
`else
  assign tie_winner = 1'b0;
`endif

  assign winner    = (pend0 & pend1) ? tie_winner : pend1;
  // Writes go first within a master; its read re-arbitrates afterwards.
  assign win_wr    = winner ? (m1_wmask != 2'b00) : (m0_wmask != 2'b00);
  assign start     = (state_q == StIdle) & (pend0 | pend1);
  assign xfer_done = ((state_q == StWr) & d_wdone) | ((state_q == StRd) & d_rdone);

  // State register plus the request latched at grant.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      mask_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        owner_q <= winner;
        if (win_wr) begin
          addr_q <= winner ? m1_waddr : m0_waddr;
          mask_q <= winner ? m1_wmask : m0_wmask;
          data_q <= winner ? m1_wdata : m0_wdata;
        end else begin
          addr_q <= winner ? m1_raddr : m0_raddr;
          mask_q <= 2'b00;
          data_q <= '0;
        end
      end
      if (xfer_done) begin
        last_q <= owner_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = win_wr ? StWr : StRd;
      StWr:    if (d_wdone) state_d = StIdle;
      StRd:    if (d_rdone) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request strobes are gated off in the done cycle so the sequencer never re-samples them.
  always_comb begin
    d_raddr  = addr_q;
    d_waddr  = addr_q;
    d_wdata  = data_q;
    d_wmask  = 2'b00;
    d_rreq   = 1'b0;
    m0_rdone = 1'b0;
    m0_wdone = 1'b0;
    m1_rdone = 1'b0;
    m1_wdone = 1'b0;
    m0_rdata = d_rdata;
    m1_rdata = d_rdata;
    busy     = (state_q != StIdle);
    grant    = owner_q;
    if (state_q == StWr) begin
      d_wmask  = d_wdone ? 2'b00 : mask_q;
      m0_wdone = d_wdone & ~owner_q;
      m1_wdone = d_wdone & owner_q;
    end
    if (state_q == StRd) begin
      d_rreq   = ~d_rdone;
      m0_rdone = d_rdone & ~owner_q;
      m1_rdone = d_rdone & owner_q;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic
// against a transaction-level arbitration model.
module tb_mem_bus_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk, reset_in;
  logic [14:0] m0_raddr, m0_waddr, m1_raddr, m1_waddr, d_raddr, d_waddr;
  logic        m0_rreq, m0_rdone, m0_wdone, m1_rreq, m1_rdone, m1_wdone;
  logic [15:0] m0_rdata, m0_wdata, m1_rdata, m1_wdata, d_rdata, d_wdata;
  logic [1:0]  m0_wmask, m1_wmask, d_wmask;
  logic        d_rreq, d_rdone, d_wdone, grant, busy;

  int n_cmp = 0;
  int n_fail = 0;

  mem_bus_arbiter dut (
    .clk(clk), .reset_in(reset_in),
    .m0_raddr(m0_raddr), .m0_rreq(m0_rreq), .m0_rdata(m0_rdata), .m0_rdone(m0_rdone),
    .m0_waddr(m0_waddr), .m0_wmask(m0_wmask), .m0_wdata(m0_wdata), .m0_wdone(m0_wdone),
    .m1_raddr(m1_raddr), .m1_rreq(m1_rreq), .m1_rdata(m1_rdata), .m1_rdone(m1_rdone),
    .m1_waddr(m1_waddr), .m1_wmask(m1_wmask), .m1_wdata(m1_wdata), .m1_wdone(m1_wdone),
    .d_raddr(d_raddr), .d_rreq(d_rreq), .d_rdata(d_rdata), .d_rdone(d_rdone),
    .d_waddr(d_waddr), .d_wmask(d_wmask), .d_wdata(d_wdata), .d_wdone(d_wdone),
    .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_raddr = '0; m0_rreq = 0; m0_waddr = '0; m0_wmask = '0; m0_wdata = '0;
    m1_raddr = '0; m1_rreq = 0; m1_waddr = '0; m1_wmask = '0; m1_wdata = '0;
    d_rdata = '0; d_rdone = 0; d_wdone = 0;
  endtask

  task automatic do_reset();
    reset_in = 1'b1;
    clear_inputs();
    tick();
    reset_in = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    clear_inputs();
    #2;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b want=0", busy); end
    n_cmp++; if (grant !== 1'b0) begin n_fail++; $display("FAIL rst_grant got=%b want=0", grant); end
    n_cmp++; if ({d_wmask, d_rreq} !== 3'b000) begin
      n_fail++; $display("FAIL rst_dreq got=%b want=000", {d_wmask, d_rreq}); end
    n_cmp++; if ({m1_wdone, m0_wdone, m1_rdone, m0_rdone} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_done got=%b want=0000", {m1_wdone, m0_wdone, m1_rdone, m0_rdone});
    end
    n_cmp++; if ({d_waddr, d_wdata} !== 31'd0) begin
      n_fail++; $display("FAIL rst_latch got=%h want=0", {d_waddr, d_wdata}); end
    tick();
    reset_in = 1'b0;
    tick();
  endtask

  task automatic test_write();
    do_reset();
    m0_waddr = 15'h1234; m0_wmask = 2'b11; m0_wdata = 16'hBEEF;
    tick();
    n_cmp++; if ({busy, grant} !== 2'b10) begin
      n_fail++; $display("FAIL wr_grant got=%b want=10", {busy, grant}); end
    n_cmp++; if ({d_waddr, d_wdata} !== {15'h1234, 16'hBEEF}) begin
      n_fail++; $display("FAIL wr_addr_data got=%h want=%h", {d_waddr, d_wdata},
                         {15'h1234, 16'hBEEF}); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({d_wmask, m0_wdone} !== 3'b110) begin
        n_fail++; $display("FAIL wr_mask_c%0d got=%b want=110", i, {d_wmask, m0_wdone}); end
      tick();
    end
    d_wdone = 1'b1;
    #1;
    n_cmp++; if ({d_wmask, m0_wdone, m1_wdone} !== 4'b0010) begin
      n_fail++; $display("FAIL wr_done got=%b want=0010", {d_wmask, m0_wdone, m1_wdone}); end
    m0_wmask = 2'b00;
    tick();
    d_wdone = 1'b0;
    #1;
    n_cmp++; if ({busy, m0_wdone, d_wmask} !== 4'b0000) begin
      n_fail++; $display("FAIL wr_after got=%b want=0000", {busy, m0_wdone, d_wmask}); end
  endtask

  task automatic test_tie();
    bit last = 1'b1;
    bit ew;
    do_reset();
    m0_raddr = 15'h0011; m1_raddr = 15'h0022;
    m0_rreq = 1'b1; m1_rreq = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ew = RR ? ~last : 1'b0;
      tick();
      n_cmp++; if ({busy, grant} !== {1'b1, ew}) begin
        n_fail++; $display("FAIL tie_grant%0d got=%b want=%b", k, {busy, grant}, {1'b1, ew}); end
      n_cmp++; if (d_raddr !== (ew ? 15'h0022 : 15'h0011)) begin
        n_fail++; $display("FAIL tie_addr%0d got=%h", k, d_raddr); end
      d_rdone = 1'b1; d_rdata = 16'h1000 + 16'(k);
      #1;
      n_cmp++; if ({m1_rdone, m0_rdone} !== (ew ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL tie_done%0d got=%b want_owner=%b", k, {m1_rdone, m0_rdone}, ew);
      end
      last = ew;
      tick();
      d_rdone = 1'b0;
    end
    clear_inputs();
  endtask

  task automatic test_wr_then_rd();
    do_reset();
    m1_waddr = 15'h0100; m1_wmask = 2'b01; m1_wdata = 16'h5A5A;
    m1_raddr = 15'h0200; m1_rreq = 1'b1;
    tick();
    n_cmp++; if ({grant, d_wmask, d_rreq} !== 4'b1010) begin
      n_fail++; $display("FAIL wrrd_wr got=%b want=1010", {grant, d_wmask, d_rreq}); end
    d_wdone = 1'b1;
    #1;
    n_cmp++; if ({m1_wdone, m1_rdone} !== 2'b10) begin
      n_fail++; $display("FAIL wrrd_wdone got=%b want=10", {m1_wdone, m1_rdone}); end
    m1_wmask = 2'b00;
    tick();
    d_wdone = 1'b0;
    #1;
    n_cmp++; if ({busy, d_rreq} !== 2'b00) begin
      n_fail++; $display("FAIL wrrd_gap got=%b want=00", {busy, d_rreq}); end
    tick();
    n_cmp++; if ({d_rreq, d_raddr} !== {1'b1, 15'h0200}) begin
      n_fail++; $display("FAIL wrrd_rd got=%h want=%h", {d_rreq, d_raddr}, {1'b1, 15'h0200}); end
    d_rdone = 1'b1; d_rdata = 16'h3C3C;
    #1;
    n_cmp++; if ({m1_rdone, m1_wdone, m1_rdata} !== {2'b10, 16'h3C3C}) begin
      n_fail++; $display("FAIL wrrd_rdone got=%h", {m1_rdone, m1_wdone, m1_rdata}); end
    m1_rreq = 1'b0;
    tick();
    d_rdone = 1'b0;
  endtask

  task automatic test_latch_hold();
    do_reset();
    m0_raddr = 15'h0010; m0_rreq = 1'b1;
    tick();
    m0_raddr = 15'h0020; m0_rreq = 1'b0;
    #1;
    n_cmp++; if ({d_rreq, d_raddr} !== {1'b1, 15'h0010}) begin
      n_fail++; $display("FAIL hold_addr got=%h want=%h", {d_rreq, d_raddr}, {1'b1, 15'h0010}); end
    tick();
    d_rdone = 1'b1; d_rdata = 16'hA5A5;
    #1;
    n_cmp++; if ({m0_rdone, m0_rdata} !== {1'b1, 16'hA5A5}) begin
      n_fail++; $display("FAIL hold_done got=%h want=%h", {m0_rdone, m0_rdata},
                         {1'b1, 16'hA5A5}); end
    tick();
    d_rdone = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_idle got=%b want=0", busy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m0_waddr = 15'h0042; m0_wmask = 2'b10; m0_wdata = 16'h1111;
    tick();
    n_cmp++; if (d_wmask !== 2'b10) begin
      n_fail++; $display("FAIL rstmid_pre got=%b want=10", d_wmask); end
    reset_in = 1'b1;
    #1;
    n_cmp++; if ({d_wmask, busy, grant} !== 4'b0000) begin
      n_fail++; $display("FAIL rstmid_async got=%b want=0000", {d_wmask, busy, grant}); end
    clear_inputs();
    tick();
    reset_in = 1'b0;
    m0_rreq = 1'b1; m1_rreq = 1'b1;
    tick();
    n_cmp++; if ({busy, grant} !== 2'b10) begin
      n_fail++; $display("FAIL rstmid_tie got=%b want=10", {busy, grant}); end
    d_rdone = 1'b1;
    #1;
    clear_inputs();
    tick();
  endtask

  task automatic test_idle_done();
    do_reset();
    d_rdone = 1'b1; d_wdone = 1'b1;
    #1;
    n_cmp++; if ({m1_wdone, m0_wdone, m1_rdone, m0_rdone} !== 4'b0000) begin
      n_fail++; $display("FAIL idle_done got=%b want=0000",
                         {m1_wdone, m0_wdone, m1_rdone, m0_rdone}); end
    tick();
    n_cmp++; if ({busy, d_rreq, d_wmask} !== 4'b0000) begin
      n_fail++; $display("FAIL idle_state got=%b want=0000", {busy, d_rreq, d_wmask}); end
    d_rdone = 1'b0; d_wdone = 1'b0;
  endtask

  // Transaction-level model: per-master pending ops, tie rule, write-before-read.
  task automatic test_random();
    bit          rp [2];
    logic [1:0]  wm [2];
    logic [14:0] ra [2], wa [2];
    logic [15:0] wd [2];
    bit          last, ew, ewr, p0, p1;
    logic [15:0] dat;
    logic [3:0]  exp_done;
    do_reset();
    last = 1'b1;
    for (int r = 0; r < 40; r++) begin
      for (int m = 0; m < 2; m++) begin
        rp[m] = 1'($urandom_range(0, 1));
        wm[m] = 2'($urandom_range(0, 3));
        ra[m] = 15'($urandom); wa[m] = 15'($urandom); wd[m] = 16'($urandom);
      end
      m0_rreq = rp[0]; m0_raddr = ra[0]; m0_waddr = wa[0]; m0_wmask = wm[0]; m0_wdata = wd[0];
      m1_rreq = rp[1]; m1_raddr = ra[1]; m1_waddr = wa[1]; m1_wmask = wm[1]; m1_wdata = wd[1];
      while (rp[0] || rp[1] || wm[0] != 0 || wm[1] != 0) begin
        p0 = rp[0] || wm[0] != 0;
        p1 = rp[1] || wm[1] != 0;
        ew = (p0 && p1) ? (RR ? ~last : 1'b0) : p1;
        ewr = (wm[ew] != 0);
        tick();
        n_cmp++; if ({busy, grant} !== {1'b1, ew}) begin
          n_fail++; $display("FAIL rnd_grant r%0d got=%b want=%b", r, {busy, grant}, {1'b1, ew});
        end
        n_cmp++;
        if (ewr) begin
          if ({d_wmask, d_rreq, d_waddr, d_wdata} !== {wm[ew], 1'b0, wa[ew], wd[ew]}) begin
            n_fail++; $display("FAIL rnd_wr r%0d got=%h want=%h", r,
                               {d_wmask, d_rreq, d_waddr, d_wdata}, {wm[ew], 1'b0, wa[ew], wd[ew]});
          end
        end else begin
          if ({d_wmask, d_rreq, d_raddr} !== {2'b00, 1'b1, ra[ew]}) begin
            n_fail++; $display("FAIL rnd_rd r%0d got=%h want=%h", r,
                               {d_wmask, d_rreq, d_raddr}, {2'b00, 1'b1, ra[ew]});
          end
        end
        repeat ($urandom_range(0, 3)) tick();
        dat = 16'($urandom);
        if (ewr) d_wdone = 1'b1;
        else begin d_rdone = 1'b1; d_rdata = dat; end
        #1;
        exp_done = ewr ? (ew ? 4'b1000 : 4'b0100) : (ew ? 4'b0010 : 4'b0001);
        n_cmp++; if ({m1_wdone, m0_wdone, m1_rdone, m0_rdone} !== exp_done) begin
          n_fail++; $display("FAIL rnd_done r%0d got=%b want=%b", r,
                             {m1_wdone, m0_wdone, m1_rdone, m0_rdone}, exp_done); end
        if (!ewr) begin
          n_cmp++; if ((ew ? m1_rdata : m0_rdata) !== dat) begin
            n_fail++; $display("FAIL rnd_rdata r%0d got=%h want=%h", r,
                               (ew ? m1_rdata : m0_rdata), dat); end
        end
        if (ewr) wm[ew] = 2'b00;
        else rp[ew] = 1'b0;
        m0_rreq = rp[0]; m0_wmask = wm[0];
        m1_rreq = rp[1]; m1_wmask = wm[1];
        last = ew;
        tick();
        d_wdone = 1'b0; d_rdone = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin
          n_fail++; $display("FAIL rnd_idle r%0d got=%b want=0", r, busy); end
      end
    end
  endtask

  initial begin
    reset_in = 1'b1;
    clear_inputs();
    test_reset();
    test_write();
    test_tie();
    test_wr_then_rd();
    test_latch_hold();
    test_reset_mid();
    test_idle_done();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have ports: reset_in  in  1  asynchronous, active-high reset.
REQ-003 SHALL have, for each master n in {0 = CPU, 1 = loader/DMA}, these ports:
- mn_raddr  in  15  read word address [15:1]
- mn_rreq  in  1  read request, level, held until mn_rdone
- mn_rdata  out  16  read data
- mn_rdone  out  1  one-cycle read completion
- mn_waddr  in  15  write word address
- mn_wmask  in  2  byte enables; nonzero = write request, held until mn_wdone
- mn_wdata  in  16  write data
- mn_wdone  out  1  one-cycle write completion
REQ-004 SHALL have the same eight ports toward the single external bus sequencer, with prefix d_ and directions mirrored.
REQ-005 SHALL have: grant  out  1  master owning the current or last transaction.
REQ-006 SHALL have: busy  out  1  a transaction is in flight.

Function
REQ-007 SHALL implement states IDLE, WR, RD, with a registered owner bit and a registered last-winner bit.
REQ-008 IDLE: a pending request is mn_rreq=1 or mn_wmask!=0.
- Only one master pending: that master wins.
- Both pending: the winner is decided per REQ-019.
- Winner has a write pending: go to WR. Otherwise go to RD.
- Write-before-read applies within one master.
REQ-009 SHALL latch the winner's address, mask and data at grant; later master-side changes SHALL NOT affect the in-flight transaction.
REQ-010 d_wmask SHALL equal the latched mask while in WR and d_wdone=0, and 0 otherwise.
- d_rreq SHALL be 1 while in RD and d_rdone=0, and 0 otherwise.
- Both are combinational gates, so the sequencer never re-samples a request in its done cycle.
REQ-011 In WR with d_wdone=1, or RD with d_rdone=1: SHALL return to IDLE and update last-winner to owner.
- The next grant SHALL occur no earlier than the following edge (minimum one idle cycle between transactions).
REQ-012 mn_rdone SHALL equal d_rdone while in RD with owner=n; mn_wdone SHALL equal d_wdone while in WR with owner=n; both SHALL be 0 otherwise. Zero added latency.
REQ-013 mn_rdata SHALL equal d_rdata for both masters at all times; it is valid only in the mn_rdone cycle.
REQ-014 A master that deasserts its request mid-transaction SHALL NOT abort it: the transaction completes and the done pulse is still issued.
REQ-015 A master with both read and write pending SHALL get the write first, then re-arbitrate for the read.
REQ-016 busy SHALL be 1 in WR or RD; grant SHALL equal the owner register.
REQ-017 Done inputs asserted while in IDLE SHALL be ignored.

Reset
REQ-018 On reset_in=1, immediately and without clk:
- state=IDLE, owner=0, last-winner=1 (so master 0 wins the first tie).
- Latched address, mask and data = 0.
- All d_ requests and all mn_ done outputs = 0; busy=0.
- A transaction in flight is abandoned; arbitration restarts from IDLE after reset_in falls.

Configuration
REQ-019 Macro MEM_ARB_ROUND_ROBIN_EN selects the tie-break:
- Defined: on a tie, the master that is not last-winner wins.
- Undefined: master 0 always wins ties; last-winner is still maintained but unused for arbitration.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- m0 write waddr=0x1234 wmask=2'b11 wdata=0xBEEF, sequencer done after 4 cycles -> d_wmask=2'b11 for 4 cycles, dropping in the d_wdone cycle; m0_wdone 1 cycle; m1_wdone 0.
- m0_rreq and m1_rreq raised on the same edge, with the macro defined -> grants 0,1,0,1 alternate over repeated requests. With the macro undefined -> m0 wins every tie while it keeps requesting.
- m1 with wmask=2'b01 and rreq both pending -> write issued first, then a read after one idle cycle; two separate done pulses.
- m0 read in flight; m0 changes m0_raddr 0x0010->0x0020 and drops m0_rreq -> d_raddr stays 0x0010; m0_rdone still pulses with d_rdata=0xA5A5.
- reset_in pulsed mid-write -> d_wmask=0 and busy=0 within the same cycle, without a clk edge; first grant after reset goes to m0 on a tie.
- d_rdone asserted while in IDLE -> no mn_rdone pulse and no state change.
